// File: rtl/pp_mat2axi_pkg.sv
// Shared types and constants for the Mat2Axi burst descriptor controller.
package pp_mat2axi_pkg;
  localparam int DIM_W  = 16;
  localparam int ADDR_W = 64;
  localparam int LEN_W  = 32;

  localparam logic [31:0] STRIDE_CONTIG = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RD_PARAM,
    ISSUE,
    DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              last;
  } desc_t;
endpackage

// File: rtl/pp_mat2axi_addr_gen.sv
// Row counter, incremental address accumulator and last-descriptor flag.
module pp_mat2axi_addr_gen
  import pp_mat2axi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              adv,
  input  logic              contig,
  input  logic [DIM_W-1:0]  rows,
  input  logic [31:0]       stride,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [DIM_W-1:0]  rows_q;
  logic [DIM_W-1:0]  row_cnt_q;
  logic [31:0]       stride_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q    <= '0;
      row_cnt_q <= '0;
      stride_q  <= '0;
      addr_q    <= '0;
      last_q    <= 1'b0;
    end else if (load) begin
      rows_q    <= rows;
      row_cnt_q <= '0;
      stride_q  <= stride;
      addr_q    <= base;
      last_q    <= contig || (rows == DIM_W'(1));
    end else if (adv) begin
      // last is precomputed one row ahead so it is a plain register at the output
      row_cnt_q <= row_cnt_q + DIM_W'(1);
      addr_q    <= addr_q + ADDR_W'(stride_q);
      last_q    <= (row_cnt_q + DIM_W'(2)) == rows_q;
    end
  end

  assign addr = addr_q;
  assign last = last_q;
endmodule

// File: rtl/pp_pipeline_accel_mat2axi_burst_ctrl.sv
// Turns rows/cols parameter tokens into per-row (or whole-frame) AXI write-burst descriptors.
// Optional PP_MAT2AXI_DESC_CNT_EN adds desc_count/frame_count outputs.
module pp_pipeline_accel_mat2axi_burst_ctrl
  import pp_mat2axi_pkg::*;
#(
  parameter int BPP = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic              ap_continue,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [31:0]       stride,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       rows_c_dout,
  input  logic              rows_c_empty_n,
  output logic              rows_c_read,
  input  logic [31:0]       cols_c_dout,
  input  logic              cols_c_empty_n,
  output logic              cols_c_read,
  output logic [ADDR_W-1:0] desc_addr,
  output logic [LEN_W-1:0]  desc_len,
  output logic              desc_last,
  input  logic              desc_full_n,
  output logic              desc_write
`ifdef PP_MAT2AXI_DESC_CNT_EN
  ,
  output logic [31:0]       desc_count,
  output logic [31:0]       frame_count
`endif
);
  state_t            state_q, state_d;
  logic [DIM_W-1:0]  rows16, cols16;
  logic              contig, load;
  logic [LEN_W-1:0]  len_q;
  logic              done_q;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_last;
  desc_t             desc;
  logic              unused_dout_hi;

  // Truncating 32-bit products give exactly the low 32 bits of the full product.
  function automatic logic [LEN_W-1:0] burst_len(input logic [DIM_W-1:0] r,
                                                 input logic [DIM_W-1:0] c,
                                                 input logic             is_contig);
    if (is_contig)
      return LEN_W'(r) * LEN_W'(c) * LEN_W'(BPP);
    return LEN_W'(c) * LEN_W'(BPP);
  endfunction

  assign rows16         = rows_c_dout[DIM_W-1:0];
  assign cols16         = cols_c_dout[DIM_W-1:0];
  assign contig         = (stride == STRIDE_CONTIG);
  assign unused_dout_hi = &{1'b0, rows_c_dout[31:DIM_W], cols_c_dout[31:DIM_W]};

  always_comb begin
    state_d     = state_q;
    rows_c_read = 1'b0;
    cols_c_read = 1'b0;
    ap_ready    = 1'b0;
    desc_write  = 1'b0;
    load        = 1'b0;
    case (state_q)
      IDLE: if (ap_start) state_d = RD_PARAM;
      RD_PARAM: begin
        if (rows_c_empty_n && cols_c_empty_n) begin
          rows_c_read = 1'b1;
          cols_c_read = 1'b1;
          ap_ready    = 1'b1;
          load        = 1'b1;
          state_d     = (rows16 == '0 || cols16 == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (desc_full_n) begin
          desc_write = 1'b1;
          if (gen_last) state_d = DONE;
        end
      end
      DONE: if (ap_continue) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
      if (load) len_q <= burst_len(rows16, cols16, contig);
    end
  end

  pp_mat2axi_addr_gen u_addr_gen (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .load   (load),
    .adv    (desc_write),
    .contig (contig),
    .rows   (rows16),
    .stride (stride),
    .base   (base_addr),
    .addr   (gen_addr),
    .last   (gen_last)
  );

  assign desc      = '{addr: gen_addr, len: len_q, last: gen_last};
  assign desc_addr = desc.addr;
  assign desc_len  = desc.len;
  assign desc_last = desc.last;
  assign ap_done   = done_q;
  assign ap_idle   = (state_q == IDLE);

`ifdef PP_MAT2AXI_DESC_CNT_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      desc_count  <= '0;
      frame_count <= '0;
    end else begin
      if (desc_write) desc_count <= desc_count + 32'd1;
      if (state_q == DONE && ap_continue) frame_count <= frame_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pp_pipeline_accel_mat2axi_burst_ctrl.sv
// Scoreboard bench for the Mat2Axi burst descriptor controller (BPP = 3).
module tb_pp_pipeline_accel_mat2axi_burst_ctrl;
  import pp_mat2axi_pkg::*;

  logic        ap_clk, ap_rst_n, ap_start, ap_continue;
  logic        ap_done, ap_idle, ap_ready;
  logic [31:0] stride;
  logic [63:0] base_addr;
  logic [31:0] rows_c_dout, cols_c_dout;
  logic        rows_c_empty_n, cols_c_empty_n, rows_c_read, cols_c_read;
  logic [63:0] desc_addr;
  logic [31:0] desc_len;
  logic        desc_last, desc_full_n, desc_write;
`ifdef PP_MAT2AXI_DESC_CNT_EN
  logic [31:0] desc_count, frame_count;
`endif

  pp_pipeline_accel_mat2axi_burst_ctrl #(.BPP(3)) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .ap_start       (ap_start),
    .ap_continue    (ap_continue),
    .ap_done        (ap_done),
    .ap_idle        (ap_idle),
    .ap_ready       (ap_ready),
    .stride         (stride),
    .base_addr      (base_addr),
    .rows_c_dout    (rows_c_dout),
    .rows_c_empty_n (rows_c_empty_n),
    .rows_c_read    (rows_c_read),
    .cols_c_dout    (cols_c_dout),
    .cols_c_empty_n (cols_c_empty_n),
    .cols_c_read    (cols_c_read),
    .desc_addr      (desc_addr),
    .desc_len       (desc_len),
    .desc_last      (desc_last),
    .desc_full_n    (desc_full_n),
    .desc_write     (desc_write)
`ifdef PP_MAT2AXI_DESC_CNT_EN
    ,
    .desc_count     (desc_count),
    .frame_count    (frame_count)
`endif
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  desc_t exp_q[$];
  int    rd_cnt, crd_cnt, rdy_cnt;
  bit    issuing;
  bit    held_v;
  desc_t held;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [31:0] l, input logic last);
    desc_t d;
    d = '{addr: a, len: l, last: last};
    exp_q.push_back(d);
  endtask

  // Monitor: pops expected descriptors on every push and checks stall stability.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      issuing = 1'b0;
      held_v  = 1'b0;
    end else begin
      desc_t cur;
      desc_t e;
      cur = '{addr: desc_addr, len: desc_len, last: desc_last};
      if (rows_c_read) rd_cnt++;
      if (cols_c_read) crd_cnt++;
      if (issuing && !desc_full_n) begin
        if (held_v) check("stall_stable", cur, held);
        else begin
          held   = cur;
          held_v = 1'b1;
        end
      end
      if (desc_write) begin
        if (held_v) begin
          check("accept_eq_stalled", cur, held);
          held_v = 1'b0;
        end
        if (exp_q.size() == 0) check("unexpected_desc_write", desc_write, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("desc_addr", desc_addr, e.addr);
          check("desc_len", desc_len, e.len);
          check("desc_last", desc_last, e.last);
          if (e.last) issuing = 1'b0;
        end
      end
      if (ap_ready) begin
        rdy_cnt++;
        check("reads_with_ready", {rows_c_read, cols_c_read}, 2'b11);
        if (exp_q.size() > 0) issuing = 1'b1;
      end
    end
  end

  task automatic run_frame(input string tag, input logic [31:0] r_in, input logic [31:0] c_in,
                           input logic [31:0] st, input logic [63:0] base, input int dly,
                           input logic [3:0] fpat, input int exp_done, input int n_desc,
                           input bit chain);
    int cyc;
`ifdef PP_MAT2AXI_DESC_CNT_EN
    logic [31:0] fc0, dc0;
    fc0 = frame_count;
    dc0 = desc_count;
`endif
    rd_cnt = 0; crd_cnt = 0; rdy_cnt = 0;
    rows_c_dout = r_in; cols_c_dout = c_in; stride = st; base_addr = base;
    rows_c_empty_n = (dly == 0);
    cols_c_empty_n = 1'b1;
    ap_start = 1'b1;
    cyc = 0;
    desc_full_n = fpat[0];
    while (ap_done !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
      if (dly > 0 && cyc == dly) begin
        check({tag, "_no_read_while_empty"}, rd_cnt, 0);
        check({tag, "_busy_in_rd_param"}, ap_idle, 1'b0);
      end
      if (rdy_cnt > 0) begin
        ap_start = 1'b0;
        rows_c_empty_n = 1'b0;
        cols_c_empty_n = 1'b0;
      end else rows_c_empty_n = (cyc >= dly);
      desc_full_n = fpat[cyc % 4];
    end
    desc_full_n = 1'b1;
    check({tag, "_done_seen"}, ap_done, 1'b1);
    if (exp_done > 0) check({tag, "_done_latency"}, cyc, exp_done);
    check({tag, "_rows_reads"}, rd_cnt, 1);
    check({tag, "_cols_reads"}, crd_cnt, 1);
    check({tag, "_ready_pulses"}, rdy_cnt, 1);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    exp_q.delete();
    ap_continue = 1'b0;
    tick(); tick();
    check({tag, "_done_held"}, ap_done, 1'b1);
    ap_continue = 1'b1;
    ap_start = chain;
    tick();
    ap_continue = 1'b0;
    check({tag, "_idle_after_continue"}, ap_idle, 1'b1);
    check({tag, "_done_cleared"}, ap_done, 1'b0);
`ifdef PP_MAT2AXI_DESC_CNT_EN
    check({tag, "_frame_count"}, frame_count, fc0 + 32'd1);
    check({tag, "_desc_count"}, desc_count, dc0 + 32'(n_desc));
`else
    if (n_desc < 0) $display("negative descriptor count for %s", tag);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    ap_rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0;
    stride = '0; base_addr = '0; rows_c_dout = '0; cols_c_dout = '0;
    rows_c_empty_n = 1'b0; cols_c_empty_n = 1'b0; desc_full_n = 1'b1;
    tick(); tick();
    check("rst_idle", ap_idle, 1'b1);
    check("rst_outputs", {ap_done, ap_ready, rows_c_read, cols_c_read, desc_write, desc_last}, 6'b0);
    check("rst_desc", {desc_addr, desc_len}, 96'b0);
    ap_rst_n = 1'b1;
    tick();

    push(64'h1000, 32'd1920, 1'b0);
    push(64'h1800, 32'd1920, 1'b0);
    push(64'h2000, 32'd1920, 1'b1);
    run_frame("strided", 32'd3, 32'd640, 32'd2048, 64'h1000, 0, 4'b1111, 5, 3, 1'b0);

    push(64'h4000_0000, 32'd6220800, 1'b1);
    run_frame("contig", 32'd1080, 32'd1920, 32'hFFFF_FFFF, 64'h4000_0000, 0, 4'b1111, 3, 1, 1'b0);

    run_frame("zero_rows", 32'd0, 32'd640, 32'd2048, 64'h1000, 0, 4'b1111, 2, 0, 1'b0);

    push(64'h8000, 32'd300, 1'b0);
    push(64'h8100, 32'd300, 1'b0);
    push(64'h8200, 32'd300, 1'b0);
    push(64'h8300, 32'd300, 1'b1);
    run_frame("backpressure", 32'd4, 32'd100, 32'h100, 64'h8000, 0, 4'b0110, 10, 4, 1'b0);

    push(64'h200, 32'd24, 1'b0);
    push(64'h240, 32'd24, 1'b1);
    run_frame("empty_fifo", 32'h0001_0002, 32'd8, 32'd64, 64'h200, 6, 4'b1111, 9, 2, 1'b1);

    push(64'hFFFF_FFFF_FFFF_F800, 32'd12, 1'b0);
    push(64'h0, 32'd12, 1'b1);
    run_frame("addr_wrap", 32'd2, 32'd4, 32'h800, 64'hFFFF_FFFF_FFFF_F800, 0, 4'b1111, 4, 2, 1'b1);

    push(64'h10, 32'hFFFA_0003, 1'b1);
    run_frame("len_trunc", 32'hFFFF, 32'hFFFF, 32'hFFFF_FFFF, 64'h10, 0, 4'b1111, 3, 1, 1'b0);

    push(64'h0, 32'd15, 1'b1);
    run_frame("one_row", 32'd1, 32'd5, 32'h40, 64'h0, 0, 4'b1111, 3, 1, 1'b0);

    // Reset while stalled in ISSUE: nothing expected in the queue, so any push is flagged.
    rows_c_dout = 32'd4; cols_c_dout = 32'd10; stride = 32'h40; base_addr = 64'h9000;
    rows_c_empty_n = 1'b1; cols_c_empty_n = 1'b1; desc_full_n = 1'b0; ap_start = 1'b1;
    tick();
    tick();
    ap_start = 1'b0; rows_c_empty_n = 1'b0; cols_c_empty_n = 1'b0;
    tick();
    check("stalled_issue_addr", desc_addr, 64'h9000);
    check("stalled_no_write", desc_write, 1'b0);
    #2 ap_rst_n = 1'b0;
    #1;
    check("midrun_rst_idle", ap_idle, 1'b1);
    check("midrun_rst_desc", {desc_addr, desc_len, desc_last}, 97'b0);
    check("midrun_rst_ctrl", {ap_done, ap_ready, rows_c_read, cols_c_read, desc_write}, 5'b0);
`ifdef PP_MAT2AXI_DESC_CNT_EN
    check("midrun_rst_counts", {desc_count, frame_count}, 64'b0);
`endif
    tick();
    ap_rst_n = 1'b1;
    desc_full_n = 1'b1;
    tick(); tick(); tick();
    check("post_rst_idle", ap_idle, 1'b1);
    check("post_rst_desc_addr", desc_addr, 64'h0);

    push(64'h1000, 32'd1920, 1'b0);
    push(64'h1800, 32'd1920, 1'b0);
    push(64'h2000, 32'd1920, 1'b1);
    run_frame("after_reset", 32'd3, 32'd640, 32'd2048, 64'h1000, 0, 4'b1111, 5, 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
